// File: rtl/decimal_keypad_debouncer.sv
// Ten-key synchroniser and press/release debouncer feeding the BCD encoder.
// Optional multi-key error pulse: define KEYPAD_MULTI_ERR_EN.
module decimal_keypad_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] keys_raw,
  output logic [9:0] D_out,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_err
);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  state_t      state;
  logic [9:0]  s1;
  logic [9:0]  keys_s;
  logic [9:0]  cand;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;

  function automatic logic is_multi(input logic [9:0] v);
    return (v & (v - 10'd1)) != 10'd0;
  endfunction

  function automatic logic is_onehot(input logic [9:0] v);
    return (v != 10'd0) && !is_multi(v);
  endfunction

  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= '0;
      keys_s    <= '0;
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      D_out     <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      s1        <= keys_raw;
      keys_s    <= s1;
      key_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (is_onehot(keys_s)) begin
            cand  <= keys_s;
            cnt   <= '0;
            state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (keys_s != cand) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            cnt       <= '0;
            state     <= PRESSED;
            D_out     <= cand;
            key_valid <= 1'b1;
            key_held  <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        PRESSED: begin
          if (keys_s == 10'd0) begin
            cnt   <= '0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (keys_s != 10'd0) begin
            cnt   <= '0;
            state <= PRESSED;
          end else if (cnt == CNT_LAST) begin
            cnt      <= '0;
            state    <= IDLE;
            key_held <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KEYPAD_MULTI_ERR_EN
  logic multi_prev;

  // Edge-detect on entering a multi-hot pattern so a held chord pulses once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      multi_prev <= 1'b0;
      multi_err  <= 1'b0;
    end else begin
      multi_prev <= is_multi(keys_s);
      multi_err  <= is_multi(keys_s) && !multi_prev &&
                    (state == IDLE || state == DEBOUNCE);
    end
  end
`else
  assign multi_err = 1'b0;
`endif

endmodule

// File: doc/decimal_keypad_debouncer.md
# decimal_keypad_debouncer

Front-end stage for the decimal-to-binary encoder. It takes ten raw, bouncing, asynchronous decimal key lines (keys 0–9) and produces a clean, registered one-hot `D_out[9:0]` that connects directly to the encoder's `D` input. It synchronises the inputs, debounces press and release, rejects multi-key presses, and emits a one-cycle `key_valid` strobe for each accepted key.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles needed to accept a press or a release; legal range 2..65535.
- `clk`  in  1  — single clock; all logic on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `keys_raw`  in  10  — raw key lines, active-high, asynchronous to `clk`; bit i = decimal key i.
- `D_out`  out  10  — registered one-hot code of the last accepted key; feeds the encoder `D`.
- `key_valid`  out  1  — one-cycle pulse when a new key is accepted.
- `key_held`  out  1  — high while the accepted key is considered down (states PRESSED and RELEASE).
- `multi_err`  out  1  — one-cycle pulse on a multi-key condition (see Configuration).

## Operation
- Synchroniser: 2-flop chain, `keys_raw` → `keys_s`. Nothing downstream uses `keys_raw` directly.
- Debounce counter `cnt`: 16 bits, saturating. It is cleared on every state transition.
- State machine:
  - IDLE
    - `keys_s` exactly one-hot: `cand <= keys_s`, `cnt <= 0`, go to DEBOUNCE.
    - `keys_s` zero or multi-hot: stay in IDLE.
  - DEBOUNCE
    - `keys_s != cand`: go to IDLE.
    - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`: go to PRESSED, `D_out <= cand`, `key_valid <= 1`.
    - Otherwise: `cnt++`.
  - PRESSED
    - `keys_s == 0`: `cnt <= 0`, go to RELEASE.
    - Any other value, including a different key or extra keys: ignored, stay in PRESSED.
  - RELEASE
    - `keys_s != 0`: go to PRESSED. No new `key_valid`; `D_out` is unchanged.
    - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`: go to IDLE.
    - Otherwise: `cnt++`.
- `D_out` holds the last accepted key indefinitely; it changes only on acceptance. It is always zero or exactly one-hot.
- `key_held` = state ∈ {PRESSED, RELEASE}.
- A second key is accepted only after a full debounced release followed by a full debounced press.

## Timing
- Reset values: state = IDLE, `D_out` = 0, `key_valid` = 0, `key_held` = 0, `multi_err` = 0, `cnt` = 0, `cand` = 0, both synchroniser stages = 0.
- Press latency, with `keys_raw` stable from rising edge E0:
  - edge E0+1: `keys_s` valid;
  - edge E0+2: IDLE captures `cand`;
  - edge E0+2+`DEBOUNCE_CYCLES`: `key_valid` and `D_out` update.
  - With the default of 16, `key_valid` is high in the cycle after edge E0+18.
- Release latency: `key_held` falls at edge E0'+2+`DEBOUNCE_CYCLES`, where E0' is the first edge at which `keys_raw == 0` is stable.
- Any `keys_s` mismatch during DEBOUNCE or RELEASE, even for a single cycle, restarts the relevant debounce from the beginning.
- `key_valid` is never asserted on two consecutive cycles.
- Asynchronous reset mid-operation: all state clears immediately. After `rst_n` deasserts, a key that is still held needs a full press latency before it is accepted.

## Configuration
- `KEYPAD_MULTI_ERR_EN` defined:
  - `multi_err` pulses for one cycle when `keys_s` transitions from a non-multi-hot value to a multi-hot value while the state is IDLE or DEBOUNCE.
  - If this happens in DEBOUNCE, the block also returns to IDLE.
- `KEYPAD_MULTI_ERR_EN` undefined:
  - `multi_err` is tied to 0.
  - Multi-hot inputs are still rejected silently; state behaviour is identical to the defined case.

## Test plan
- Clean press: after reset, hold key 7 (`keys_raw` = 10'b0010000000) for 40 cycles, then release for 40 cycles.
  - `key_valid` pulses once, 18 edges after the input becomes stable.
  - `D_out` = 10'b0010000000 and stays there.
  - `key_held` falls 18 edges after release.
- Bounce reject: toggle key 3 with a 5-cycle period for 60 cycles, then hold it for 20 cycles.
  - No `key_valid` during the toggling.
  - Exactly one `key_valid` during the hold, with `D_out` = 10'b0000001000.
- Release glitch: accept key 2, release it, then re-press it for 1 cycle at 10 cycles into RELEASE.
  - The block returns to PRESSED with no new `key_valid`.
  - `key_held` stays high until 16 clean zero cycles have elapsed.
- Multi-key: press keys 1 and 4 together for 40 cycles.
  - No `key_valid`; `D_out` unchanged.
  - With `KEYPAD_MULTI_ERR_EN`, exactly one `multi_err` pulse.
- Held-key override: accept key 0, then press key 9 while key 0 is still held.
  - No acceptance of key 9 until both keys are released for 16 cycles and key 9 is then pressed alone.
- Reset mid-debounce: drive `rst_n` = 0 at DEBOUNCE `cnt` = 10, with key 5 held throughout.
  - All outputs read 0 during reset.
  - `key_valid` occurs 18 edges after `rst_n` rises.
